dcache_set_assoc: RTL and testbench
===================================

// Module: dcache_set_assoc
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache between the LSQ/mem stage and the
//  shared memory bus. Blocking: at most one miss outstanding. Per-set LRU replacement and a flush engine that
//  writes every dirty line back before program halt. Lines are one 64-bit memory block (8 bytes).
// PARAMETERS
//  NUM_SETS   32  sets; power of 2, >=2
//  NUM_WAYS   2   ways per set; power of 2, 1..8
//  SET_BITS   $clog2(NUM_SETS)  derived; tag = addr[`XLEN-1:SET_BITS+3]
// PORTS
//  clk                 in   1      clock; one clock domain
//  rst                 in   1      synchronous, active-high reset
//  proc2cache_command  in   BUS_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE; sampled only while cache2proc_ready=1
//  proc2cache_addr     in   `XLEN  byte address; must be naturally aligned for proc2cache_size
//  proc2cache_data     in   `XLEN  store data, right-justified
//  proc2cache_size     in   MEM_SIZE  BYTE/HALF/WORD
//  cache2proc_ready    out  1      cache can accept a request this cycle
//  cache2proc_valid    out  1      one-cycle pulse: request completed (load data valid / store retired)
//  cache2proc_data     out  `XLEN  load result, zero-extended
//  flush_req           in   1      start write-back of all dirty lines; sampled only while ready=1
//  flush_done          out  1      one-cycle pulse when flush finishes
//  cache2mem_command   out  BUS_COMMAND  memory request
//  cache2mem_addr      out  `XLEN  block address, bits[2:0]=0
//  cache2mem_data      out  64     write-back line data
//  cache2mem_size      out  MEM_SIZE  always DOUBLE when command!=BUS_NONE
//  mem2cache_response  in   4      nonzero = request accepted, value is transaction tag; 0 = retry
//  mem2cache_data      in   64     fill data, valid when mem2cache_tag == saved tag
//  mem2cache_tag       in   4      tag of returning load; 0 = nothing
// BEHAVIOUR
//  Reset: all valid/dirty/LRU cleared, FSM=IDLE, saved tag=0; ready=1, valid=0, data=0, flush_done=0,
//   cache2mem_command=BUS_NONE, addr/data=0, size=DOUBLE. Reset mid-miss or mid-flush drops it: dirty data lost,
//   later mem2cache_tag for the old tag ignored (saved tag 0 never matches).
//  Address split: offset=addr[2:0], set=addr[SET_BITS+2:3], tag=upper bits.
//  States: IDLE, WB_REQ, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB. cache2proc_ready=1 only in IDLE.
//  IDLE hit (any way valid & tag match): registered response next cycle (1-cycle latency). Load returns bytes
//   [offset*8 +: size]; store merges bytes into the line, sets dirty. LRU updated. Stays IDLE.
//  IDLE miss: victim = lowest-index invalid way, else LRU way. Latch request. Victim dirty -> WB_REQ, else FILL_REQ.
//  WB_REQ: drive BUS_STORE, addr={victim tag,set,3'b0}, data=victim line. response!=0 -> clear victim dirty,
//   FILL_REQ; response==0 -> hold outputs, retry next cycle.
//  FILL_REQ: drive BUS_LOAD, addr={tag,set,3'b0}. response!=0 -> save tag, command=BUS_NONE, FILL_WAIT; else retry.
//  FILL_WAIT: on mem2cache_tag==saved tag: install line valid, tag; load -> dirty=0, extract data;
//   store -> merge store bytes, dirty=1. Pulse cache2proc_valid same edge; LRU update; saved tag=0; -> IDLE.
//   Tag match in the same cycle the tag is saved (FILL_REQ) is not possible and need not be handled.
//  LRU: per-set age counter per way, $clog2(NUM_WAYS) bits, reset to way index. On access/fill of way w with age
//   a: age[w]=0, every way with age<a increments. LRU way = the one with max age. NUM_WAYS=1: always way 0.
//  Flush: flush_req in IDLE (priority over proc2cache_command, which is then ignored) -> FLUSH_SCAN over
//   (set,way) in ascending set then way order. Dirty valid line -> FLUSH_WB: BUS_STORE, retry on response 0,
//   on accept clear dirty, advance. After last entry pulse flush_done, -> IDLE. Lines stay valid after flush.
//  Misaligned or DOUBLE processor requests are illegal (simulation assertion); behaviour undefined.
//  No outstanding-load coalescing; only one memory transaction in flight.
// TESTING
//  1. Reset, load WORD 0x100 (miss) -> BUS_LOAD 0x100; respond tag 3, return tag 3 data 0x1111_2222_3333_4444
//     -> valid pulse, data 0x3333_4444; repeat load 0x104 -> hit, data 0x1111_2222 one cycle later, no bus op.
//  2. Store BYTE 0xAB to 0x103 after test 1 -> hit, next load WORD 0x100 returns 0xAB33_4444, line dirty.
//  3. NUM_WAYS=2, NUM_SETS=32: fill 0x100, 0x200 (same set 0), touch 0x100, miss 0x300 -> victim is 0x200's way;
//     if 0x200 dirty, BUS_STORE 0x200 precedes BUS_LOAD 0x300.
//  4. Hold mem2cache_response=0 for 5 cycles during WB_REQ and FILL_REQ -> command/addr/data held stable, ready=0.
//  5. Dirty lines at sets 0 and 5 -> flush_req -> exactly two BUS_STORE DOUBLE (set 0 first), flush_done pulse.
//  6. Assert rst in FILL_WAIT, then present old tag on mem2cache_tag -> no valid pulse, cache empty, ready=1.

Source files
------------

// File: rtl/dcache_set_assoc_if.sv
// Shared bus types plus the processor/memory-side interface of the data cache.
// The cache uses the slave view; the surrounding pipeline and memory use the master view.
package dcache_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} bus_command_t;
    typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} mem_size_t;
endpackage

interface dcache_set_assoc_if;
    import dcache_pkg::*;

    bus_command_t      proc2cache_command;
    logic [XLEN-1:0]   proc2cache_addr;
    logic [XLEN-1:0]   proc2cache_data;
    mem_size_t         proc2cache_size;
    logic              cache2proc_ready;
    logic              cache2proc_valid;
    logic [XLEN-1:0]   cache2proc_data;
    logic              flush_req;
    logic              flush_done;
    bus_command_t      cache2mem_command;
    logic [XLEN-1:0]   cache2mem_addr;
    logic [63:0]       cache2mem_data;
    mem_size_t         cache2mem_size;
    logic [3:0]        mem2cache_response;
    logic [63:0]       mem2cache_data;
    logic [3:0]        mem2cache_tag;

    modport slave (
        input  proc2cache_command, proc2cache_addr, proc2cache_data, proc2cache_size, flush_req,
               mem2cache_response, mem2cache_data, mem2cache_tag,
        output cache2proc_ready, cache2proc_valid, cache2proc_data, flush_done,
               cache2mem_command, cache2mem_addr, cache2mem_data, cache2mem_size
    );

    modport master (
        output proc2cache_command, proc2cache_addr, proc2cache_data, proc2cache_size, flush_req,
               mem2cache_response, mem2cache_data, mem2cache_tag,
        input  cache2proc_ready, cache2proc_valid, cache2proc_data, flush_done,
               cache2mem_command, cache2mem_addr, cache2mem_data, cache2mem_size
    );
endinterface

// File: rtl/dcache_set_assoc.sv
// Blocking N-way set-associative write-back/write-allocate data cache with per-set age LRU
// and a flush engine that writes back every dirty line.
module dcache_set_assoc
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 2,
    parameter int SET_BITS = $clog2(NUM_SETS)
) (
    input  logic              clk,
    input  logic              rst,
    dcache_set_assoc_if.slave bus
);
    localparam int TAG_W = XLEN - SET_BITS - 3;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int AGE_W = WAY_W;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0]    LAST_WAY = WAY_W'(NUM_WAYS - 1);

    typedef logic [NUM_WAYS-1:0][AGE_W-1:0] age_vec_t;
    typedef enum logic [2:0] {IDLE, WB_REQ, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t              state, state_n;
    logic [63:0]         data_mem [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid    [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty    [NUM_SETS];
    age_vec_t            age      [NUM_SETS];
    logic [3:0]          saved_tag;

    bus_command_t        req_cmd;
    logic [XLEN-1:0]     req_addr, req_wdata;
    mem_size_t           req_size;
    logic [WAY_W-1:0]    victim, victim_n;
    logic [SET_BITS-1:0] scan_set, scan_set_nx;
    logic [WAY_W-1:0]    scan_way, scan_way_nx;

    logic [SET_BITS-1:0] in_set, req_set, wb_set;
    logic [TAG_W-1:0]    in_tag, req_tag;
    logic [2:0]          in_off, req_off;
    logic [WAY_W-1:0]    hit_way, wb_way;
    logic hit, req_go, hit_go, miss_go, mem_accept, fill_hit, last_entry, scan_dirty, misaligned;

    function automatic logic [XLEN-1:0] load_extract(input logic [63:0] line, input logic [2:0] off,
                                                     input mem_size_t size);
        logic [63:0] sh;
        sh = line >> {off, 3'b000};
        case (size)
            BYTE:    return {{(XLEN-8){1'b0}}, sh[7:0]};
            HALF:    return {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return sh[XLEN-1:0];
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] line, input logic [2:0] off,
                                                input mem_size_t size, input logic [XLEN-1:0] wdata);
        logic [63:0] mask, val;
        case (size)
            BYTE:    mask = 64'h0000_0000_0000_00FF;
            HALF:    mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        val  = 64'(wdata) & mask;
        mask = mask << {off, 3'b000};
        val  = val << {off, 3'b000};
        return (line & ~mask) | val;
    endfunction

    // Touched way becomes youngest; every way younger than it ages by one, keeping ages a permutation.
    function automatic age_vec_t lru_touch(input age_vec_t a, input logic [WAY_W-1:0] w);
        age_vec_t r;
        r = a;
        for (int i = 0; i < NUM_WAYS; i++)
            if (a[i] < a[w]) r[i] = a[i] + AGE_W'(1);
        r[w] = '0;
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] lru_way(input age_vec_t a);
        logic [WAY_W-1:0] best;
        best = '0;
        for (int i = 1; i < NUM_WAYS; i++)
            if (a[i] > a[best]) best = WAY_W'(i);
        return best;
    endfunction

    assign in_set  = bus.proc2cache_addr[SET_BITS+2:3];
    assign in_tag  = bus.proc2cache_addr[XLEN-1:SET_BITS+3];
    assign in_off  = bus.proc2cache_addr[2:0];
    assign req_set = req_addr[SET_BITS+2:3];
    assign req_tag = req_addr[XLEN-1:SET_BITS+3];
    assign req_off = req_addr[2:0];

    assign req_go     = (state == IDLE) && !bus.flush_req && (bus.proc2cache_command != BUS_NONE);
    assign hit_go     = req_go && hit;
    assign miss_go    = req_go && !hit;
    assign mem_accept = (bus.mem2cache_response != 4'd0);
    assign fill_hit   = (bus.mem2cache_tag == saved_tag) && (saved_tag != 4'd0);
    assign last_entry = (scan_set == LAST_SET) && (scan_way == LAST_WAY);
    assign scan_dirty = valid[scan_set][scan_way] && dirty[scan_set][scan_way];
    assign scan_way_nx = (scan_way == LAST_WAY) ? '0 : scan_way + WAY_W'(1);
    assign scan_set_nx = (scan_way == LAST_WAY) ? scan_set + SET_BITS'(1) : scan_set;
    assign wb_set = (state == FLUSH_WB) ? scan_set : req_set;
    assign wb_way = (state == FLUSH_WB) ? scan_way : victim;
    assign misaligned = ((bus.proc2cache_size == HALF) && bus.proc2cache_addr[0]) ||
                        ((bus.proc2cache_size == WORD) && (bus.proc2cache_addr[1:0] != 2'b00));

    assign bus.cache2proc_ready = (state == IDLE);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (valid[in_set][i] && (tag_mem[in_set][i] == in_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
    end

    // Lowest-index invalid way wins over the LRU way.
    always_comb begin
        victim_n = lru_way(age[in_set]);
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid[in_set][i]) victim_n = WAY_W'(i);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.flush_req)
                    state_n = FLUSH_SCAN;
                else if (miss_go)
                    state_n = (valid[in_set][victim_n] && dirty[in_set][victim_n]) ? WB_REQ : FILL_REQ;
            end
            WB_REQ:     if (mem_accept) state_n = FILL_REQ;
            FILL_REQ:   if (mem_accept) state_n = FILL_WAIT;
            FILL_WAIT:  if (fill_hit)   state_n = IDLE;
            FLUSH_SCAN: begin
                if (scan_dirty)      state_n = FLUSH_WB;
                else if (last_entry) state_n = IDLE;
            end
            FLUSH_WB:   if (mem_accept) state_n = last_entry ? IDLE : FLUSH_SCAN;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.cache2mem_command = BUS_NONE;
        bus.cache2mem_addr    = '0;
        bus.cache2mem_data    = '0;
        bus.cache2mem_size    = DOUBLE;
        case (state)
            WB_REQ, FLUSH_WB: begin
                bus.cache2mem_command = BUS_STORE;
                bus.cache2mem_addr    = {tag_mem[wb_set][wb_way], wb_set, 3'b000};
                bus.cache2mem_data    = data_mem[wb_set][wb_way];
            end
            FILL_REQ: begin
                bus.cache2mem_command = BUS_LOAD;
                bus.cache2mem_addr    = {req_tag, req_set, 3'b000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            saved_tag            <= '0;
            scan_set             <= '0;
            scan_way             <= '0;
            bus.cache2proc_valid <= 1'b0;
            bus.cache2proc_data  <= '0;
            bus.flush_done       <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= AGE_W'(w);
            end
        end else begin
            state                <= state_n;
            bus.cache2proc_valid <= 1'b0;
            bus.flush_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        scan_set <= '0;
                        scan_way <= '0;
                    end else if (hit_go) begin
                        bus.cache2proc_valid <= 1'b1;
                        bus.cache2proc_data  <= (bus.proc2cache_command == BUS_LOAD) ?
                            load_extract(data_mem[in_set][hit_way], in_off, bus.proc2cache_size) : '0;
                        if (bus.proc2cache_command == BUS_STORE) dirty[in_set][hit_way] <= 1'b1;
                        age[in_set] <= lru_touch(age[in_set], hit_way);
                    end
                end
                WB_REQ:   if (mem_accept) dirty[req_set][victim] <= 1'b0;
                FILL_REQ: if (mem_accept) saved_tag <= bus.mem2cache_response;
                FILL_WAIT: begin
                    if (fill_hit) begin
                        valid[req_set][victim] <= 1'b1;
                        dirty[req_set][victim] <= (req_cmd == BUS_STORE);
                        age[req_set]           <= lru_touch(age[req_set], victim);
                        saved_tag              <= '0;
                        bus.cache2proc_valid   <= 1'b1;
                        bus.cache2proc_data    <= (req_cmd == BUS_LOAD) ?
                            load_extract(bus.mem2cache_data, req_off, req_size) : '0;
                    end
                end
                FLUSH_SCAN: begin
                    if (!scan_dirty) begin
                        if (last_entry) bus.flush_done <= 1'b1;
                        else begin
                            scan_set <= scan_set_nx;
                            scan_way <= scan_way_nx;
                        end
                    end
                end
                FLUSH_WB: begin
                    if (mem_accept) begin
                        dirty[scan_set][scan_way] <= 1'b0;
                        if (last_entry) bus.flush_done <= 1'b1;
                        else begin
                            scan_set <= scan_set_nx;
                            scan_way <= scan_way_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage and the latched miss request carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && hit_go && (bus.proc2cache_command == BUS_STORE))
            data_mem[in_set][hit_way] <= store_merge(data_mem[in_set][hit_way], in_off,
                                                     bus.proc2cache_size, bus.proc2cache_data);
        if (!rst && miss_go) begin
            req_cmd   <= bus.proc2cache_command;
            req_addr  <= bus.proc2cache_addr;
            req_wdata <= bus.proc2cache_data;
            req_size  <= bus.proc2cache_size;
            victim    <= victim_n;
        end
        if (!rst && (state == FILL_WAIT) && fill_hit) begin
            data_mem[req_set][victim] <= (req_cmd == BUS_STORE) ?
                store_merge(bus.mem2cache_data, req_off, req_size, req_wdata) : bus.mem2cache_data;
            tag_mem[req_set][victim]  <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_go)
            assert (!misaligned && (bus.proc2cache_size != DOUBLE));
    end
endmodule

// File: tb/tb_dcache_set_assoc.sv
// Directed vector bench for dcache_set_assoc: table of accesses with hand-computed bus traffic
// and load data, plus hand-written flush, retry and reset-mid-miss sequences.
module tb_dcache_set_assoc;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_set_assoc_if bus();

    dcache_set_assoc #(.NUM_SETS(32), .NUM_WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bus_command_t cmd;
        logic [31:0]  addr;
        mem_size_t    size;
        logic [31:0]  wdata;
        bit           hit;
        bit           wb;
        logic [31:0]  wb_addr;
        logic [63:0]  wb_data;
        logic [31:0]  fill_addr;
        logic [63:0]  fill_data;
        logic [31:0]  rdata;
    } vec_t;

    vec_t        vecs [0:16];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  tag_ctr = 4'd3;
    logic [31:0] seen_addr [0:3];
    logic [63:0] seen_data [0:3];
    int          n_wb, done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        string n;
        n = $sformatf("v%0d", idx);
        chk({n, ".ready"}, bus.cache2proc_ready, 1);
        bus.proc2cache_command = v.cmd;
        bus.proc2cache_addr    = v.addr;
        bus.proc2cache_size    = v.size;
        bus.proc2cache_data    = v.wdata;
        tick();
        bus.proc2cache_command = BUS_NONE;
        if (v.hit) begin
            chk({n, ".hit_valid"}, bus.cache2proc_valid, 1);
            chk({n, ".hit_nobus"}, bus.cache2mem_command, BUS_NONE);
            if (v.cmd == BUS_LOAD) chk({n, ".hit_data"}, bus.cache2proc_data, v.rdata);
        end else begin
            chk({n, ".miss_valid"}, bus.cache2proc_valid, 0);
            if (v.wb) begin
                chk({n, ".wb_cmd"}, bus.cache2mem_command, BUS_STORE);
                chk({n, ".wb_addr"}, bus.cache2mem_addr, v.wb_addr);
                chk({n, ".wb_data"}, bus.cache2mem_data, v.wb_data);
                chk({n, ".wb_size"}, bus.cache2mem_size, DOUBLE);
                bus.mem2cache_response = 4'd1;
                tick();
                bus.mem2cache_response = 4'd0;
            end
            chk({n, ".fill_cmd"}, bus.cache2mem_command, BUS_LOAD);
            chk({n, ".fill_addr"}, bus.cache2mem_addr, v.fill_addr);
            bus.mem2cache_response = tag_ctr;
            tick();
            bus.mem2cache_response = 4'd0;
            chk({n, ".wait_cmd"}, bus.cache2mem_command, BUS_NONE);
            bus.mem2cache_tag  = tag_ctr;
            bus.mem2cache_data = v.fill_data;
            tick();
            bus.mem2cache_tag = 4'd0;
            chk({n, ".fill_valid"}, bus.cache2proc_valid, 1);
            if (v.cmd == BUS_LOAD) chk({n, ".fill_data"}, bus.cache2proc_data, v.rdata);
            tag_ctr = (tag_ctr == 4'd15) ? 4'd1 : tag_ctr + 4'd1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.proc2cache_command = BUS_NONE;
        bus.proc2cache_addr    = '0;
        bus.proc2cache_data    = '0;
        bus.proc2cache_size    = WORD;
        bus.flush_req          = 1'b0;
        bus.mem2cache_response = 4'd0;
        bus.mem2cache_data     = '0;
        bus.mem2cache_tag      = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst.ready", bus.cache2proc_ready, 1);
        chk("rst.valid", bus.cache2proc_valid, 0);
        chk("rst.data", bus.cache2proc_data, 0);
        chk("rst.flush_done", bus.flush_done, 0);
        chk("rst.mem_cmd", bus.cache2mem_command, BUS_NONE);
        chk("rst.mem_addr", bus.cache2mem_addr, 0);
        chk("rst.mem_data", bus.cache2mem_data, 0);
        chk("rst.mem_size", bus.cache2mem_size, DOUBLE);

        //         cmd        addr          size   wdata          hit   wb    wb_addr       wb_data                  fill_addr     fill_data                rdata
        vecs[0]  = '{BUS_LOAD,  32'h100, WORD, 32'h0,         1'b0, 1'b0, 32'h0,   64'h0,                   32'h100, 64'h1111_2222_3333_4444, 32'h3333_4444};
        vecs[1]  = '{BUS_LOAD,  32'h104, WORD, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h1111_2222};
        vecs[2]  = '{BUS_STORE, 32'h103, BYTE, 32'hAB,        1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0};
        vecs[3]  = '{BUS_LOAD,  32'h100, WORD, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'hAB33_4444};
        vecs[4]  = '{BUS_LOAD,  32'h106, HALF, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0000_1111};
        vecs[5]  = '{BUS_STORE, 32'h200, WORD, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,   64'h0,                   32'h200, 64'h5555_6666_7777_8888, 32'h0};
        vecs[6]  = '{BUS_LOAD,  32'h204, BYTE, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0000_0066};
        vecs[7]  = '{BUS_LOAD,  32'h100, WORD, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'hAB33_4444};
        vecs[8]  = '{BUS_LOAD,  32'h300, WORD, 32'h0,         1'b0, 1'b1, 32'h200, 64'h5555_6666_DEAD_BEEF, 32'h300, 64'h0102_0304_0506_0708, 32'h0506_0708};
        vecs[9]  = '{BUS_LOAD,  32'h204, WORD, 32'h0,         1'b0, 1'b1, 32'h100, 64'h1111_2222_AB33_4444, 32'h200, 64'h5555_6666_DEAD_BEEF, 32'h5555_6666};
        vecs[10] = '{BUS_LOAD,  32'h301, BYTE, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0000_0007};
        vecs[11] = '{BUS_STORE, 32'h12A, HALF, 32'hCAFE,      1'b0, 1'b0, 32'h0,   64'h0,                   32'h128, 64'h0,                   32'h0};
        vecs[12] = '{BUS_LOAD,  32'h128, WORD, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'hCAFE_0000};
        vecs[13] = '{BUS_STORE, 32'h300, WORD, 32'h1234_5678, 1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0};
        vecs[14] = '{BUS_STORE, 32'h307, BYTE, 32'h99,        1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'h0};
        vecs[15] = '{BUS_LOAD,  32'h200, WORD, 32'h0,         1'b1, 1'b0, 32'h0,   64'h0,                   32'h0,   64'h0,                   32'hDEAD_BEEF};
        vecs[16] = '{BUS_LOAD,  32'h404, WORD, 32'h0,         1'b0, 1'b0, 32'h0,   64'h0,                   32'h400, 64'h1357_9BDF_2468_ACE0, 32'h1357_9BDF};

        for (int i = 0; i < 14; i++) apply(vecs[i], i);

        // Flush: dirty lines at set 0 (0x300) and set 5 (0x128) only.
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        n_wb = 0;
        done_cnt = 0;
        for (int c = 0; c < 300 && done_cnt == 0; c++) begin
            if (bus.flush_done) done_cnt++;
            if (bus.cache2mem_command == BUS_STORE) begin
                if (n_wb < 4) begin
                    seen_addr[n_wb] = bus.cache2mem_addr;
                    seen_data[n_wb] = bus.cache2mem_data;
                end
                chk("flush.size", bus.cache2mem_size, DOUBLE);
                n_wb++;
                bus.mem2cache_response = 4'd2;
            end else begin
                bus.mem2cache_response = 4'd0;
            end
            tick();
        end
        bus.mem2cache_response = 4'd0;
        chk("flush.done_seen", done_cnt, 1);
        chk("flush.count", n_wb, 2);
        chk("flush.addr0", seen_addr[0], 32'h300);
        chk("flush.data0", seen_data[0], 64'h0102_0304_1234_5678);
        chk("flush.addr1", seen_addr[1], 32'h128);
        chk("flush.data1", seen_data[1], 64'h0000_0000_CAFE_0000);
        chk("flush.done_pulse", bus.flush_done, 0);
        chk("flush.ready", bus.cache2proc_ready, 1);

        for (int i = 14; i < 16; i++) apply(vecs[i], i);

        // Miss on 0x404 evicts dirty 0x300; memory refuses 5 cycles at each request.
        chk("retry.ready0", bus.cache2proc_ready, 1);
        bus.proc2cache_command = BUS_LOAD;
        bus.proc2cache_addr    = 32'h404;
        bus.proc2cache_size    = WORD;
        tick();
        bus.proc2cache_command = BUS_NONE;
        for (int k = 0; k < 5; k++) begin
            chk("retry.wb_cmd", bus.cache2mem_command, BUS_STORE);
            chk("retry.wb_addr", bus.cache2mem_addr, 32'h300);
            chk("retry.wb_data", bus.cache2mem_data, 64'h9902_0304_1234_5678);
            chk("retry.wb_ready", bus.cache2proc_ready, 0);
            tick();
        end
        bus.mem2cache_response = 4'd1;
        tick();
        bus.mem2cache_response = 4'd0;
        for (int k = 0; k < 5; k++) begin
            chk("retry.fill_cmd", bus.cache2mem_command, BUS_LOAD);
            chk("retry.fill_addr", bus.cache2mem_addr, 32'h400);
            chk("retry.fill_ready", bus.cache2proc_ready, 0);
            tick();
        end
        bus.mem2cache_response = 4'd9;
        tick();
        bus.mem2cache_response = 4'd0;
        chk("retry.wait_cmd", bus.cache2mem_command, BUS_NONE);
        bus.mem2cache_tag  = 4'd9;
        bus.mem2cache_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        bus.mem2cache_tag = 4'd0;
        chk("retry.valid", bus.cache2proc_valid, 1);
        chk("retry.data", bus.cache2proc_data, 32'hAAAA_BBBB);

        // Reset while waiting for fill data; the stale tag must be ignored afterwards.
        bus.proc2cache_command = BUS_LOAD;
        bus.proc2cache_addr    = 32'h500;
        tick();
        bus.proc2cache_command = BUS_NONE;
        chk("rstmid.fill_cmd", bus.cache2mem_command, BUS_LOAD);
        chk("rstmid.fill_addr", bus.cache2mem_addr, 32'h500);
        bus.mem2cache_response = 4'd7;
        tick();
        bus.mem2cache_response = 4'd0;
        chk("rstmid.wait_ready", bus.cache2proc_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.ready", bus.cache2proc_ready, 1);
        bus.mem2cache_tag  = 4'd7;
        bus.mem2cache_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstmid.no_valid", bus.cache2proc_valid, 0);
            chk("rstmid.no_bus", bus.cache2mem_command, BUS_NONE);
        end
        bus.mem2cache_tag = 4'd0;

        // 0x404 was resident before reset; it must now miss with no write-back.
        apply(vecs[16], 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
